// File: rtl/start_window_pkg.sv
// Shared types for the start-window checker: FSM states and fail-reason codes.
package start_window_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_EN_DROP = 2'b01,
    FC_TIMEOUT = 2'b10
  } fail_code_t;

endpackage

// File: rtl/start_window_checker_rise_detect.sv
// Rising-edge detector: registers d and flags the cycle where d is high but was low.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q_reg <= 1'b0;
    end else begin
      d_q_reg <= d;
    end
  end

  // Cleared history after reset makes an already-high d count as a rise.
  assign rise = d & ~d_q_reg;

endmodule

// File: rtl/start_window_checker.sv
// Checks that start arrives within WINDOW cycles of an en rise while en stays high;
// reports pass/fail pulses with a reason code and keeps saturating event counts.
module start_window_checker
  import start_window_pkg::*;
#(
  parameter int WINDOW = 20,
  parameter int CNT_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           start,
  output logic                           busy,
  output logic                           pass,
  output logic                           fail,
  output logic [1:0]                     fail_code,
  output logic [CNT_W-1:0]               pass_cnt,
  output logic [CNT_W-1:0]               fail_cnt,
  output logic [$clog2(WINDOW+1)-1:0]    wait_cycles
);

  localparam int WC_W = $clog2(WINDOW+1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_reg;
  logic   rise;
  logic   pass_evt;
  logic   fail_evt;

  rise_detect u_rise_detect (
    .clk  (clk),
    .rst  (rst),
    .d    (en),
    .rise (rise)
  );

  // Event strobes decoded from the same priority rules the FSM applies below.
  always_comb begin
    pass_evt = 1'b0;
    fail_evt = 1'b0;
    if (state_reg == IDLE) begin
      pass_evt = rise & start;
    end else begin
      fail_evt = ~en | (~start & (wait_cycles == WC_LAST));
      pass_evt = en & start;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      busy        <= 1'b0;
      wait_cycles <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= FC_NONE;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
    end else begin
      pass      <= pass_evt;
      fail      <= fail_evt;
      fail_code <= FC_NONE;

      case (state_reg)
        IDLE: begin
          if (rise && !start) begin
            state_reg   <= WAIT;
            busy        <= 1'b1;
            wait_cycles <= WC_W'(1);
          end
        end
        WAIT: begin
          if (!en) begin
            fail_code <= FC_EN_DROP;
          end else if (!start && wait_cycles == WC_LAST) begin
            fail_code <= FC_TIMEOUT;
          end

          if (pass_evt || fail_evt) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            wait_cycles <= '0;
          end else begin
            wait_cycles <= wait_cycles + 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          busy        <= 1'b0;
          wait_cycles <= '0;
        end
      endcase

      if (pass_evt && pass_cnt != CNT_MAX) begin
        pass_cnt <= pass_cnt + 1'b1;
      end
      if (fail_evt && fail_cnt != CNT_MAX) begin
        fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/start_window_checker.md
START_WINDOW_CHECKER -- requirements
Module: start_window_checker

Interface
REQ-001 The block SHALL have parameter WINDOW, default 20, which is the maximum number of cycles after an enable rise within which start is accepted.
REQ-002 The block SHALL have parameter CNT_W, default 8, which is the width of the pass and fail event counters.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, width 1: the enable level that must hold from its rise until start.
REQ-006 The block SHALL have port start, input, width 1: the start strobe that closes the window.
REQ-007 The block SHALL have port busy, output, width 1: high while a window is open (state WAIT).
REQ-008 The block SHALL have port pass, output, width 1: a 1-cycle pulse when a window closes successfully.
REQ-009 The block SHALL have port fail, output, width 1: a 1-cycle pulse when a window closes with a violation.
REQ-010 The block SHALL have port fail_code, output, width 2: 00 none, 01 EN_DROP, 10 TIMEOUT; valid while fail=1, and 00 otherwise.
REQ-011 The block SHALL have port pass_cnt, output, width CNT_W: the saturating count of pass events.
REQ-012 The block SHALL have port fail_cnt, output, width CNT_W: the saturating count of fail events.
REQ-013 The block SHALL have port wait_cycles, output, width $clog2(WINDOW+1): the number of cycles elapsed in the current window.

Function
REQ-014 en_q SHALL register en every cycle, and rise SHALL be defined as en & ~en_q.
REQ-015 The FSM SHALL have exactly two states, IDLE and WAIT.
REQ-016 The rise cycle SHALL be relative cycle 0 for that window.
REQ-017 In IDLE, if rise and start are both high in the same cycle, the block SHALL register a pass and remain in IDLE.
REQ-018 In IDLE, if rise is high and start is low, the block SHALL go to WAIT and set wait_cycles to 1.
REQ-019 In IDLE with no rise, start SHALL be ignored.
REQ-020 In WAIT, the checks SHALL be evaluated in this priority order:
  - en=0 (start value irrelevant) -> fail with code EN_DROP, next state IDLE.
  - else start=1 -> pass, next state IDLE.
  - else wait_cycles==WINDOW -> fail with code TIMEOUT, next state IDLE.
  - else wait_cycles increments and the state remains WAIT.
REQ-021 A start SHALL be accepted at any relative cycle from 0 to WINDOW inclusive; a TIMEOUT fail SHALL be evaluated at relative cycle WINDOW.
REQ-022 pass, fail and fail_code SHALL be registered and SHALL appear in the cycle after the evaluating cycle, for exactly 1 cycle each.
REQ-023 pass and fail SHALL never be high in the same cycle.
REQ-024 busy SHALL equal (state==WAIT) and SHALL be registered.
REQ-025 wait_cycles SHALL read 0 in IDLE.
REQ-026 pass_cnt and fail_cnt SHALL each increment by one per event and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 After an EN_DROP fail, a later rise of en SHALL open a new window normally.
REQ-028 A rise cannot occur while in WAIT, because en would have already dropped and failed the window.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set state=IDLE, en_q=0, wait_cycles=0, busy=0, pass=0, fail=0, fail_code=00, pass_cnt=0 and fail_cnt=0.
REQ-030 If en is high in the first cycle after rst is released, that cycle SHALL count as a rise.
REQ-031 A reset asserted mid-window SHALL abandon the window silently, with no pass or fail pulse.

Structure
REQ-032 Package start_window_pkg SHALL hold the state enum (IDLE, WAIT) and the fail-code enum (FC_NONE=2'b00, FC_EN_DROP=2'b01, FC_TIMEOUT=2'b10).
REQ-033 The block SHALL contain exactly one sub-module, rise_detect, a registered edge detector that outputs rise and has a synchronous active-high reset.
REQ-034 The FSM, window counter and saturating counters SHALL reside in the top module.

Verification (clk period 10 ns, WINDOW=20; cycle 0 is the en rise cycle)
REQ-035 en rises at cycle 0 and is held, start pulses at cycle 8 -> pass=1 at cycle 9, pass_cnt=1, busy falls at cycle 9.
REQ-036 en rises at cycle 0, start is also high at cycle 0 -> pass at cycle 1, busy stays 0 throughout.
REQ-037 en rises at cycle 0, en drops at cycle 3, start pulses at cycle 5 -> fail=1 with fail_code=01 at cycle 4, and no pass at cycle 6.
REQ-038 en rises at cycle 0 and is held, start never occurs -> fail=1 with fail_code=10 at cycle 21, fail_cnt=1; a start at cycle 20 instead -> pass at cycle 21.
REQ-039 en rises at cycle 0, rst is asserted at cycle 4 -> at cycle 5 busy=0 and counters=0, with no pulses; en held high through reset release -> a new window opens.
REQ-040 With CNT_W=2, five consecutive passing windows -> pass_cnt reads 3 after the third pass and stays at 3.
